// File: rtl/risc_v_pkg.sv
// -----------------------------------------------------------------------------
// risc_v_pkg
// Shared definitions for the single-cycle RV32I core:
//   - RV32I major opcodes and funct7 encodings
//   - ALU operation, immediate-format and write-back select enums
//   - decoded control bundle (ctrl_t) and its do-nothing default
//   - gen_imm(): sign-extended immediate for each instruction format
// -----------------------------------------------------------------------------
package risc_v_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MUL
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4,
        WB_IMM
    } wb_sel_e;

    typedef struct packed {
        logic     reg_write;
        logic     mem_write;
        logic     is_branch;
        logic     is_jal;
        logic     is_jalr;
        logic     a_pc;      // ALU operand A is the PC instead of rs1
        logic     b_imm;     // ALU operand B is the immediate instead of rs2
        alu_op_e  alu_op;
        imm_sel_e imm_sel;
        wb_sel_e  wb_sel;
    } ctrl_t;

    // Anything not explicitly decoded falls back to this: PC+4 with no side effects.
    localparam ctrl_t CTRL_NOP = '{
        reg_write: 1'b0,
        mem_write: 1'b0,
        is_branch: 1'b0,
        is_jal:    1'b0,
        is_jalr:   1'b0,
        a_pc:      1'b0,
        b_imm:     1'b0,
        alu_op:    ALU_ADD,
        imm_sel:   IMM_I,
        wb_sel:    WB_ALU
    };

    // Base-ISA ALU op selected by funct3; 'alt' picks SUB/SRA over ADD/SRL.
    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_sel_e sel);
        logic [31:0] imm;
        case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/risc_v_alu.sv
// -----------------------------------------------------------------------------
// risc_v_alu
// Purely combinational RV32I ALU.
//   a_i       [31:0]  operand A
//   b_i       [31:0]  operand B (shift amount taken from b_i[4:0])
//   alu_op_i          operation select (alu_op_e)
//   result_o  [31:0]  result, modulo 2^32
// Build option: RISC_V_MUL_EN enables ALU_MUL (low 32 bits of a*b); without
// it ALU_MUL yields zero and the decoder never selects it.
// -----------------------------------------------------------------------------
module risc_v_alu
    import risc_v_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     alu_op_i,
    output logic [31:0] result_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives result_o and no latch is inferred.
        result_o = 32'd0;
        case (alu_op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {31'd0, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = 32'($signed(a_i) >>> b_i[4:0]);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
`ifdef RISC_V_MUL_EN
            ALU_MUL:  result_o = a_i * b_i;
`else
            ALU_MUL:  result_o = 32'd0;
`endif
            default:  result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/risc_v.sv
// -----------------------------------------------------------------------------
// risc_v
// Single-cycle RV32I core: one instruction fetched, executed and retired per
// rising clock edge. Holds the PC, the 32x32 register file, the decoder,
// immediate generator, instruction ROM and byte-enabled data RAM.
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous active-low reset (PC, x1..x31 and out cleared)
//   out  [31:0]  last value written back to a nonzero rd (registered)
// Parameters: IMEM_DEPTH / DMEM_DEPTH in 32-bit words, IMEM_FILE names the
// ROM image, RESET_PC.
// Build option: RISC_V_MUL_EN decodes funct7=0000001/funct3=000 as MUL;
// without it that encoding retires as a NOP.
// -----------------------------------------------------------------------------
module risc_v
    import risc_v_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter string       IMEM_FILE  = "program.hex",
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] out
);

    localparam int unsigned IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    // ------------------------------------------------------------------ state
    logic [31:0] pc_q, pc_d;
    logic [31:0] out_q, out_d;
    logic [31:0] rf_q [32];
    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];

    // ------------------------------------------------------------------ fetch
    logic [IAW-1:0] imem_idx;
    logic [31:0]    instr;

    // PC[1:0] is ignored; the word index wraps modulo the ROM depth.
    assign imem_idx = IAW'(pc_q[31:2] % 30'(IMEM_DEPTH));
    assign instr    = imem[imem_idx];

    logic [6:0] opcode, funct7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // ----------------------------------------------------------------- decode
    ctrl_t ctrl;

    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm_sel   = IMM_U;
                ctrl.wb_sel    = WB_IMM;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm_sel   = IMM_U;
                ctrl.a_pc      = 1'b1;
                ctrl.b_imm     = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.is_jal    = 1'b1;
                ctrl.imm_sel   = IMM_J;
                ctrl.wb_sel    = WB_PC4;
            end
            OP_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.is_jalr   = 1'b1;
                ctrl.b_imm     = 1'b1;
                ctrl.wb_sel    = WB_PC4;
            end
            OP_BRANCH: begin
                // funct3 010/011 are not branches and stay NOPs.
                if (funct3[2:1] != 2'b01) begin
                    ctrl.is_branch = 1'b1;
                    ctrl.imm_sel   = IMM_B;
                end
            end
            OP_LOAD: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.b_imm     = 1'b1;
                    ctrl.wb_sel    = WB_MEM;
                end
            end
            OP_STORE: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
                    ctrl.mem_write = 1'b1;
                    ctrl.b_imm     = 1'b1;
                    ctrl.imm_sel   = IMM_S;
                end
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.b_imm     = 1'b1;
                // Only the right shift uses instr[30] to pick SRAI over SRLI.
                ctrl.alu_op    = alu_op_from_f3(funct3, (funct3 == 3'b101) && instr[30]);
            end
            OP_REG: begin
                if (funct7 == F7_BASE) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = alu_op_from_f3(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = alu_op_from_f3(funct3, 1'b1);
                end
`ifdef RISC_V_MUL_EN
                else if (funct7 == F7_MULDIV && funct3 == 3'b000) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALU_MUL;
                end
`endif
            end
            default: ctrl = CTRL_NOP;
        endcase
    end

    // ------------------------------------------------- operands and execute
    logic [31:0] imm, rs1_data, rs2_data, alu_a, alu_b, alu_res;

    assign imm      = gen_imm(instr, ctrl.imm_sel);
    assign rs1_data = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
    assign alu_a    = ctrl.a_pc  ? pc_q : rs1_data;
    assign alu_b    = ctrl.b_imm ? imm  : rs2_data;

    risc_v_alu u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .alu_op_i (ctrl.alu_op),
        .result_o (alu_res)
    );

    // ---------------------------------------------------------- branch / PC
    logic        branch_taken;
    logic [31:0] pc_plus4, pc_rel;

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_rel   = pc_q + imm;

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = (rs1_data == rs2_data);
            3'b001:  branch_taken = (rs1_data != rs2_data);
            3'b100:  branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  branch_taken = (rs1_data <  rs2_data);
            3'b111:  branch_taken = (rs1_data >= rs2_data);
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d = pc_plus4;
        if (ctrl.is_jal || (ctrl.is_branch && branch_taken)) pc_d = pc_rel;
        else if (ctrl.is_jalr)                               pc_d = {alu_res[31:1], 1'b0};
    end

    // ---------------------------------------------------------- data memory
    logic [DAW-1:0] dmem_idx;
    logic [31:0]    mem_word, load_data, store_data;
    logic [3:0]     store_be;
    logic [7:0]     lane_byte;
    logic [15:0]    lane_half;

    // Misaligned halfword/word accesses land in the aligned containing word.
    assign dmem_idx  = DAW'(alu_res[31:2] % 30'(DMEM_DEPTH));
    assign mem_word  = dmem[dmem_idx];
    assign lane_byte = mem_word[{alu_res[1:0], 3'b000} +: 8];
    assign lane_half = alu_res[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        load_data = mem_word;
        case (funct3)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_data = {24'd0, lane_byte};
            3'b101:  load_data = {16'd0, lane_half};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        store_data = rs2_data;
        store_be   = 4'b1111;
        case (funct3)
            3'b000: begin
                store_data = {4{rs2_data[7:0]}};
                store_be   = 4'b0001 << alu_res[1:0];
            end
            3'b001: begin
                store_data = {2{rs2_data[15:0]}};
                store_be   = alu_res[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = rs2_data;
                store_be   = 4'b1111;
            end
        endcase
    end

    // NOTE: RAM contents are deliberately not reset, so this block has no reset branch;
    // the reset level only suppresses writes while the core is held.
    always_ff @(posedge clk) begin
        if (reset && ctrl.mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (store_be[b]) dmem[dmem_idx][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    // ----------------------------------------------------------- write-back
    logic [31:0] wb_data;
    logic        rf_we;

    always_comb begin
        wb_data = alu_res;
        case (ctrl.wb_sel)
            WB_MEM:  wb_data = load_data;
            WB_PC4:  wb_data = pc_plus4;
            WB_IMM:  wb_data = imm;
            default: wb_data = alu_res;
        endcase
    end

    assign rf_we = ctrl.reg_write && (rd != 5'd0);
    assign out_d = rf_we ? wb_data : out_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; a same-cycle read of rd sees the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            out_q <= 32'd0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            pc_q  <= pc_d;
            out_q <= out_d;
            if (rf_we) rf_q[rd] <= wb_data;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_risc_v.sv
// -----------------------------------------------------------------------------
// tb_risc_v
// Directed self-checking bench for the risc_v core. Programs are written into
// the instruction ROM while the core is held in reset; each step waits one
// rising edge and compares 'out' and the PC against hand-computed values.
// -----------------------------------------------------------------------------
module tb_risc_v;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] out;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    risc_v #(
        .IMEM_DEPTH (1024),
        .DMEM_DEPTH (1024),
        .IMEM_FILE  (""),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    // ------------------------------------------------------------- encoders
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    // ------------------------------------------------------------- helpers
    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        dut.imem[addr[11:2]] = word;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) dut.imem[i] = NOP;
    endtask

    // Hold reset (asynchronously) for two cycles, check the reset state, release on a negedge.
    task automatic hold_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({tag, " out async"}, out, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, " out"}, out, 32'd0);
        check({tag, " pc"}, dut.pc_q, 32'd0);
        reset = 1'b1;
    endtask

    // One instruction retires per rising edge; sample on the following negedge.
    task automatic step(input string tag, input logic [31:0] exp_out, input logic [31:0] exp_pc);
        @(negedge clk);
        check({tag, " out"}, out, exp_out);
        check({tag, " pc"}, dut.pc_q, exp_pc);
    endtask

    initial begin
        reset = 1'b0;

        // ------------------------------------------ program 1: ALU and x0/NOP
        clear_imem();
        put(32'h00, enc_i(32'd5,         5'd0, 3'b000, 5'd1,  7'h13)); // ADDI x1,x0,5
        put(32'h04, enc_i(32'hFFFF_FFFD, 5'd0, 3'b000, 5'd1,  7'h13)); // ADDI x1,x0,-3
        put(32'h08, enc_i(32'd7,         5'd0, 3'b000, 5'd2,  7'h13)); // ADDI x2,x0,7
        put(32'h0C, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));           // ADD  x3,x1,x2
        put(32'h10, enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4));           // SUB  x4,x1,x2
        put(32'h14, enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd5));           // SLT  x5,x1,x2
        put(32'h18, enc_i(32'd9,         5'd0, 3'b000, 5'd0,  7'h13)); // ADDI x0,x0,9
        put(32'h1C, enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd6));           // SLTU x6,x1,x2
        put(32'h20, enc_i(32'd3,         5'd0, 3'b000, 5'd7,  7'h13)); // ADDI x7,x0,3
        put(32'h24, 32'h0000_007F);                                    // unknown opcode
        put(32'h28, enc_i(32'h401,       5'd1, 3'b101, 5'd8,  7'h13)); // SRAI x8,x1,1
        put(32'h2C, enc_i(32'd28,        5'd1, 3'b101, 5'd9,  7'h13)); // SRLI x9,x1,28
        put(32'h30, enc_i(32'd4,         5'd2, 3'b001, 5'd10, 7'h13)); // SLLI x10,x2,4
        put(32'h34, enc_i(32'hFFFF_FFFF, 5'd2, 3'b011, 5'd11, 7'h13)); // SLTIU x11,x2,-1
        put(32'h38, enc_i(32'h0F0,       5'd1, 3'b111, 5'd12, 7'h13)); // ANDI x12,x1,0xF0

        hold_reset("rst1");
        step("addi5",  32'h0000_0005, 32'h04);
        step("addi-3", 32'hFFFF_FFFD, 32'h08);
        step("addi7",  32'h0000_0007, 32'h0C);
        step("add",    32'h0000_0004, 32'h10);
        step("sub",    32'hFFFF_FFF6, 32'h14);
        step("slt",    32'h0000_0001, 32'h18);
        step("x0wr",   32'h0000_0001, 32'h1C);
        step("sltu",   32'h0000_0000, 32'h20);
        step("x0rd",   32'h0000_0003, 32'h24);
        step("unkop",  32'h0000_0003, 32'h28);
        step("srai",   32'hFFFF_FFFE, 32'h2C);
        step("srli",   32'h0000_000F, 32'h30);
        step("slli",   32'h0000_0070, 32'h34);
        step("sltiu",  32'h0000_0001, 32'h38);
        step("andi",   32'h0000_00F0, 32'h3C);

        // Reset dropped between clock edges clears state immediately.
        #2;
        reset = 1'b0;
        #1;
        check("midrst out", out, 32'd0);
        check("midrst pc", dut.pc_q, 32'd0);
        @(negedge clk);
        check("midrst held out", out, 32'd0);
        reset = 1'b1;
        step("restart0", 32'h0000_0005, 32'h04);
        step("restart1", 32'hFFFF_FFFD, 32'h08);

        // -------------------------------- program 2: memory, branches, jumps
        @(negedge clk);
        reset = 1'b0;
        clear_imem();
        put(32'h00, enc_u(20'h80000, 5'd1, 7'h37));                    // LUI  x1,0x80000
        put(32'h04, enc_i(32'd1,  5'd1, 3'b000, 5'd1, 7'h13));         // ADDI x1,x1,1
        put(32'h08, enc_s(32'd8,  5'd1, 5'd0, 3'b010));                // SW   x1,8(x0)
        put(32'h0C, enc_i(32'd8,  5'd0, 3'b000, 5'd2, 7'h03));         // LB   x2,8(x0)
        put(32'h10, enc_i(32'd11, 5'd0, 3'b100, 5'd3, 7'h03));         // LBU  x3,11(x0)
        put(32'h14, enc_i(32'd10, 5'd0, 3'b001, 5'd4, 7'h03));         // LH   x4,10(x0)
        put(32'h18, enc_s(32'd8,  5'd0, 5'd0, 3'b000));                // SB   x0,8(x0)
        put(32'h1C, enc_i(32'd8,  5'd0, 3'b010, 5'd5, 7'h03));         // LW   x5,8(x0)
        put(32'h20, enc_j(32'd8,  5'd1));                              // JAL  x1,+8
        put(32'h24, enc_j(32'd16, 5'd0));                              // JAL  x0,+16
        put(32'h28, enc_b(32'd8,  5'd0, 5'd0, 3'b000));                // BEQ  x0,x0,+8
        put(32'h2C, enc_i(32'h77, 5'd0, 3'b000, 5'd6, 7'h13));         // skipped
        put(32'h30, enc_i(32'd0,  5'd1, 3'b000, 5'd0, 7'h67));         // JALR x0,0(x1)
        put(32'h34, enc_b(32'd8,  5'd2, 5'd4, 3'b100));                // BLT  x4,x2,+8
        put(32'h38, enc_i(32'h66, 5'd0, 3'b000, 5'd6, 7'h13));         // skipped
        put(32'h3C, enc_b(32'd8,  5'd2, 5'd4, 3'b110));                // BLTU x4,x2,+8
        put(32'h40, enc_b(32'd8,  5'd4, 5'd2, 3'b101));                // BGE  x2,x4,+8
        put(32'h44, enc_i(32'h44, 5'd0, 3'b000, 5'd6, 7'h13));         // skipped
        put(32'h48, enc_b(32'd8,  5'd2, 5'd4, 3'b111));                // BGEU x4,x2,+8
        put(32'h4C, enc_i(32'h4C, 5'd0, 3'b000, 5'd6, 7'h13));         // skipped
        put(32'h50, enc_b(32'd8,  5'd3, 5'd2, 3'b001));                // BNE  x2,x3,+8
        put(32'h54, enc_i(32'h54, 5'd0, 3'b000, 5'd6, 7'h13));         // skipped
        put(32'h58, enc_u(20'h00001, 5'd7, 7'h17));                    // AUIPC x7,1
        put(32'h5C, enc_u(20'h00010, 5'd8, 7'h37));                    // LUI  x8,0x10
        put(32'h60, enc_i(32'd1,  5'd8, 3'b000, 5'd9, 7'h13));         // ADDI x9,x8,1
        put(32'h64, enc_r(7'h01, 5'd9, 5'd8, 3'b000, 5'd10));          // MUL  x10,x8,x9
        put(32'h68, enc_r(7'h01, 5'd9, 5'd8, 3'b001, 5'd11));          // MULH encoding
        put(32'h6C, enc_b(32'd0,  5'd0, 5'd0, 3'b000));                // BEQ  x0,x0,0

        hold_reset("rst2");
        step("lui",    32'h8000_0000, 32'h04);
        step("addi1",  32'h8000_0001, 32'h08);
        step("sw",     32'h8000_0001, 32'h0C);
        step("lb",     32'h0000_0001, 32'h10);
        step("lbu",    32'h0000_0080, 32'h14);
        step("lh",     32'hFFFF_8000, 32'h18);
        step("sb",     32'hFFFF_8000, 32'h1C);
        step("lw",     32'h8000_0000, 32'h20);
        step("jal",    32'h0000_0024, 32'h28);
        step("beq",    32'h0000_0024, 32'h30);
        step("jalr",   32'h0000_0024, 32'h24);
        step("jal_x0", 32'h0000_0024, 32'h34);
        step("blt",    32'h0000_0024, 32'h3C);
        step("bltu_n", 32'h0000_0024, 32'h40);
        step("bge",    32'h0000_0024, 32'h48);
        step("bgeu",   32'h0000_0024, 32'h50);
        step("bne",    32'h0000_0024, 32'h58);
        step("auipc",  32'h0000_1058, 32'h5C);
        step("lui10",  32'h0001_0000, 32'h60);
        step("addi9",  32'h0001_0001, 32'h64);
`ifdef RISC_V_MUL_EN
        step("mul",    32'h0001_0000, 32'h68);
        step("mulh",   32'h0001_0000, 32'h6C);
`else
        step("mul",    32'h0001_0001, 32'h68);
        step("mulh",   32'h0001_0001, 32'h6C);
`endif
        step("loop0",  (`ifdef RISC_V_MUL_EN 32'h0001_0000 `else 32'h0001_0001 `endif), 32'h6C);
        step("loop1",  (`ifdef RISC_V_MUL_EN 32'h0001_0000 `else 32'h0001_0001 `endif), 32'h6C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
